druaga_input_cond: RTL and testbench



---
 rtl/druaga_input_pkg.sv | 121 ++++++++++++
 rtl/druaga_coin_shaper.sv | 60 ++++++
 rtl/druaga_input_cond.sv | 112 +++++++++++
 tb/tb_druaga_input_cond.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/druaga_input_pkg.sv
// druaga_input_pkg: scan codes, joystick/INP bit positions, coin FSM states and decode helpers
// shared by the Druaga input conditioning stage.
package druaga_input_pkg;

    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_CTRL  = 8'h14;
    localparam logic [7:0] SC_1     = 8'h16;
    localparam logic [7:0] SC_2     = 8'h1E;
    localparam logic [7:0] SC_5     = 8'h2E;
    localparam logic [7:0] SC_F1    = 8'h05;
    localparam logic [7:0] SC_F2    = 8'h06;
    localparam logic [7:0] SC_R     = 8'h2D;
    localparam logic [7:0] SC_F     = 8'h2B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_G     = 8'h34;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_6     = 8'h36;

    localparam int JS_R    = 0;
    localparam int JS_L    = 1;
    localparam int JS_D    = 2;
    localparam int JS_U    = 3;
    localparam int JS_T1   = 4;
    localparam int JS_T2   = 5;
    localparam int JS_S1   = 6;
    localparam int JS_S2   = 7;
    localparam int JS_COIN = 8;

    localparam int INP_UP     = 0;
    localparam int INP_RIGHT  = 1;
    localparam int INP_DOWN   = 2;
    localparam int INP_LEFT   = 3;
    localparam int INP_TRIG1  = 4;
    localparam int INP_TRIG2  = 5;
    localparam int INP_START1 = 0;
    localparam int INP_START2 = 1;
    localparam int INP_COIN   = 2;

    // One held-state bit per physical key, so shared functions (F1 vs 1/5) release independently.
    localparam int K_UP    = 0;
    localparam int K_DOWN  = 1;
    localparam int K_LEFT  = 2;
    localparam int K_RIGHT = 3;
    localparam int K_SPACE = 4;
    localparam int K_CTRL  = 5;
    localparam int K_1     = 6;
    localparam int K_2     = 7;
    localparam int K_5     = 8;
    localparam int K_F1    = 9;
    localparam int K_F2    = 10;
    localparam int K_R     = 11;
    localparam int K_F     = 12;
    localparam int K_D     = 13;
    localparam int K_G     = 14;
    localparam int K_A     = 15;
    localparam int K_S     = 16;
    localparam int K_6     = 17;
    localparam int NKEYS   = 18;

    typedef enum logic [1:0] {IDLE, PULSE, HOLD, WAITREL} coin_state_t;

    // Arrows accept the E0 prefix or not; every other key must arrive unextended.
    function automatic logic [NKEYS-1:0] key_hit(input logic ext, input logic [7:0] code);
        logic [NKEYS-1:0] h;
        h = '0;
        case (code)
            SC_UP:    h[K_UP]    = 1'b1;
            SC_DOWN:  h[K_DOWN]  = 1'b1;
            SC_LEFT:  h[K_LEFT]  = 1'b1;
            SC_RIGHT: h[K_RIGHT] = 1'b1;
            SC_SPACE: h[K_SPACE] = !ext;
            SC_CTRL:  h[K_CTRL]  = !ext;
            SC_1:     h[K_1]     = !ext;
            SC_2:     h[K_2]     = !ext;
            SC_5:     h[K_5]     = !ext;
            SC_F1:    h[K_F1]    = !ext;
            SC_F2:    h[K_F2]    = !ext;
            SC_R:     h[K_R]     = !ext;
            SC_F:     h[K_F]     = !ext;
            SC_D:     h[K_D]     = !ext;
            SC_G:     h[K_G]     = !ext;
            SC_A:     h[K_A]     = !ext;
            SC_S:     h[K_S]     = !ext;
            SC_6:     h[K_6]     = !ext;
            default:  h = '0;
        endcase
        return h;
    endfunction

    function automatic logic [5:0] joy_to_inp(input logic [5:0] j);
        logic [5:0] r;
        r = '0;
        r[INP_UP]    = j[JS_U];
        r[INP_RIGHT] = j[JS_R];
        r[INP_DOWN]  = j[JS_D];
        r[INP_LEFT]  = j[JS_L];
        r[INP_TRIG1] = j[JS_T1];
        r[INP_TRIG2] = j[JS_T2];
        return r;
    endfunction

    function automatic logic [5:0] socd(input logic [5:0] p);
        logic [5:0] r;
        r = p;
        if (p[INP_UP] && p[INP_DOWN]) begin
            r[INP_UP]   = 1'b0;
            r[INP_DOWN] = 1'b0;
        end
        if (p[INP_LEFT] && p[INP_RIGHT]) begin
            r[INP_LEFT]  = 1'b0;
            r[INP_RIGHT] = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/druaga_coin_shaper.sv
// druaga_coin_shaper: turns each coin_raw rising edge into a COIN_FRAMES-long pulse
// followed by HOLD_FRAMES of holdoff, counted on vblank rising edges.
module druaga_coin_shaper
    import druaga_input_pkg::*;
#(
    parameter int COIN_FRAMES = 4,
    parameter int HOLD_FRAMES = 4
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic coin_raw,
    input  logic vblank,
    output logic coin
);

    localparam logic [3:0] C_LAST = 4'(COIN_FRAMES - 1);
    localparam logic [3:0] H_LAST = 4'(HOLD_FRAMES - 1);

    coin_state_t r_state;
    logic [3:0]  r_cnt;
    logic        r_vbl_d;
    logic        r_coin_d;
    logic        w_vbl_rise;
    logic        w_coin_rise;

    assign w_vbl_rise  = vblank & ~r_vbl_d;
    assign w_coin_rise = coin_raw & ~r_coin_d;

    // Edges seen outside IDLE are simply lost: one insertion, one pulse.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_vbl_d  <= 1'b0;
            r_coin_d <= 1'b0;
        end else begin
            r_vbl_d  <= vblank;
            r_coin_d <= coin_raw;
            case (r_state)
                IDLE: if (w_coin_rise) begin
                    r_state <= PULSE;
                    r_cnt   <= '0;
                end
                PULSE: if (w_vbl_rise) begin
                    r_cnt <= (r_cnt == C_LAST) ? 4'd0 : r_cnt + 4'd1;
                    if (r_cnt == C_LAST) r_state <= (HOLD_FRAMES == 0) ? WAITREL : HOLD;
                end
                HOLD: if (w_vbl_rise) begin
                    r_cnt <= (r_cnt == H_LAST) ? 4'd0 : r_cnt + 4'd1;
                    if (r_cnt == H_LAST) r_state <= WAITREL;
                end
                WAITREL: if (!coin_raw) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign coin = (r_state == PULSE);

endmodule

// File: rtl/druaga_input_cond.sv
// druaga_input_cond: PS/2 + joystick merge and coin shaping feeding INP0/INP1/INP2.
// Define DRUAGA_INPUT_SOCD_EN to neutralise opposing directions per player.
module druaga_input_cond
    import druaga_input_pkg::*;
#(
    parameter int COIN_FRAMES = 4,
    parameter int HOLD_FRAMES = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystk1,
    input  logic [15:0] joystk2,
    input  logic        cabinet,
    input  logic        vblank,
    output logic [5:0]  inp0,
    output logic [5:0]  inp1,
    output logic [2:0]  inp2
);

    logic             r_tog_d;
    logic             r_primed;
    logic [NKEYS-1:0] r_keys;
    logic [5:0]       r_inp0;
    logic [5:0]       r_inp1;
    logic [1:0]       r_start;
    logic             w_evt;
    logic [NKEYS-1:0] w_hit;
    logic [5:0]       w_key_p1;
    logic [5:0]       w_key_p2;
    logic [5:0]       w_p1_raw;
    logic [5:0]       w_p2_raw;
    logic [5:0]       w_p1;
    logic [5:0]       w_p2;
    logic [1:0]       w_start;
    logic             w_coin_raw;
    logic             w_coin;
    logic             w_unused;

    assign w_unused = ^{joystk1[15:9], joystk2[15:9]};

    // The first clock out of reset only captures the toggle bit, so a stale level is not a keypress.
    assign w_evt = r_primed & (ps2_key[10] ^ r_tog_d);
    assign w_hit = w_evt ? key_hit(ps2_key[8], ps2_key[7:0]) : '0;

    always_comb begin
        w_key_p1            = '0;
        w_key_p1[INP_UP]    = r_keys[K_UP];
        w_key_p1[INP_RIGHT] = r_keys[K_RIGHT];
        w_key_p1[INP_DOWN]  = r_keys[K_DOWN];
        w_key_p1[INP_LEFT]  = r_keys[K_LEFT];
        w_key_p1[INP_TRIG1] = r_keys[K_SPACE];
        w_key_p1[INP_TRIG2] = r_keys[K_CTRL];
        w_key_p2            = '0;
        w_key_p2[INP_UP]    = r_keys[K_R];
        w_key_p2[INP_RIGHT] = r_keys[K_G];
        w_key_p2[INP_DOWN]  = r_keys[K_F];
        w_key_p2[INP_LEFT]  = r_keys[K_D];
        w_key_p2[INP_TRIG1] = r_keys[K_A];
        w_key_p2[INP_TRIG2] = r_keys[K_S];
    end

    assign w_p2_raw = w_key_p2 | joy_to_inp(joystk2[5:0]);
    assign w_p1_raw = w_key_p1 | joy_to_inp(joystk1[5:0]) | (cabinet ? 6'd0 : w_p2_raw);

`ifdef DRUAGA_INPUT_SOCD_EN
    assign w_p1 = socd(w_p1_raw);
    assign w_p2 = socd(w_p2_raw);
`else
    assign w_p1 = w_p1_raw;
    assign w_p2 = w_p2_raw;
`endif

    assign w_start[INP_START1] = joystk1[JS_S1] | joystk2[JS_S1] | r_keys[K_1] | r_keys[K_F1];
    assign w_start[INP_START2] = joystk1[JS_S2] | joystk2[JS_S2] | r_keys[K_2] | r_keys[K_F2];
    assign w_coin_raw = joystk1[JS_COIN] | joystk2[JS_COIN] | r_keys[K_5] | r_keys[K_6]
                      | r_keys[K_F1] | r_keys[K_F2];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_tog_d  <= 1'b0;
            r_primed <= 1'b0;
            r_keys   <= '0;
            r_inp0   <= '0;
            r_inp1   <= '0;
            r_start  <= '0;
        end else begin
            r_tog_d  <= ps2_key[10];
            r_primed <= 1'b1;
            r_keys   <= (r_keys & ~w_hit) | (w_hit & {NKEYS{ps2_key[9]}});
            r_inp0   <= w_p1;
            r_inp1   <= w_p2;
            r_start  <= w_start;
        end
    end

    druaga_coin_shaper #(
        .COIN_FRAMES(COIN_FRAMES),
        .HOLD_FRAMES(HOLD_FRAMES)
    ) u_coin (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .coin_raw(w_coin_raw),
        .vblank  (vblank),
        .coin    (w_coin)
    );

    assign inp0 = r_inp0;
    assign inp1 = r_inp1;
    assign inp2 = {w_coin, r_start};

endmodule

// File: tb/tb_druaga_input_cond.sv
// tb_druaga_input_cond: directed and randomized checks of key decode, merge, fold and coin shaping.
module tb_druaga_input_cond;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] ps2_key = '0;
    logic [15:0] joystk1 = '0;
    logic [15:0] joystk2 = '0;
    logic        cabinet = 1'b0;
    logic        vblank  = 1'b0;
    logic [5:0]  inp0, inp1, inp0_b, inp1_b;
    logic [2:0]  inp2, inp2_b;

    int total = 0;
    int bad   = 0;
    bit kd [256];
    int hi, rises, hi0, rises0;
    logic prev, prev0;

    always #5 clk_sys = ~clk_sys;

    druaga_input_cond #(.COIN_FRAMES(4), .HOLD_FRAMES(4)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joystk1(joystk1),
        .joystk2(joystk2), .cabinet(cabinet), .vblank(vblank),
        .inp0(inp0), .inp1(inp1), .inp2(inp2));

    druaga_input_cond #(.COIN_FRAMES(1), .HOLD_FRAMES(0)) dut_b (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key), .joystk1(joystk1),
        .joystk2(joystk2), .cabinet(cabinet), .vblank(vblank),
        .inp0(inp0_b), .inp1(inp1_b), .inp2(inp2_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_arrow(input logic [7:0] c);
        return c == 8'h75 || c == 8'h72 || c == 8'h6B || c == 8'h74;
    endfunction

    function automatic bit is_known(input logic [7:0] c);
        logic [7:0] l [14] = '{8'h29, 8'h14, 8'h16, 8'h1E, 8'h2E, 8'h05, 8'h06,
                               8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B, 8'h36};
        foreach (l[i]) if (l[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // Drive one PS/2 event (toggle flips) and record its meaning in the model.
    task automatic send_key(input bit ext, input logic [7:0] code, input bit pressed);
        ps2_key = {~ps2_key[10], pressed, ext, code};
        if (is_arrow(code) || (!ext && is_known(code))) kd[code] = pressed;
    endtask

    task automatic model(output logic [5:0] e0, output logic [5:0] e1, output logic [1:0] es);
        bit u2, d2, l2, r2, a2, b2, u1, d1, l1, r1, a1, b1;
        u2 = kd[8'h2D] | joystk2[3];  d2 = kd[8'h2B] | joystk2[2];
        l2 = kd[8'h23] | joystk2[1];  r2 = kd[8'h34] | joystk2[0];
        a2 = kd[8'h1C] | joystk2[4];  b2 = kd[8'h1B] | joystk2[5];
        u1 = kd[8'h75] | joystk1[3] | (!cabinet & u2);
        d1 = kd[8'h72] | joystk1[2] | (!cabinet & d2);
        l1 = kd[8'h6B] | joystk1[1] | (!cabinet & l2);
        r1 = kd[8'h74] | joystk1[0] | (!cabinet & r2);
        a1 = kd[8'h29] | joystk1[4] | (!cabinet & a2);
        b1 = kd[8'h14] | joystk1[5] | (!cabinet & b2);
`ifdef DRUAGA_INPUT_SOCD_EN
        if (u1 && d1) begin u1 = 0; d1 = 0; end
        if (l1 && r1) begin l1 = 0; r1 = 0; end
        if (u2 && d2) begin u2 = 0; d2 = 0; end
        if (l2 && r2) begin l2 = 0; r2 = 0; end
`endif
        e0 = {b1, a1, l1, d1, r1, u1};
        e1 = {b2, a2, l2, d2, r2, u2};
        es = {kd[8'h1E] | kd[8'h06] | joystk1[7] | joystk2[7],
              kd[8'h16] | kd[8'h05] | joystk1[6] | joystk2[6]};
    endtask

    task automatic check_all(input string tag);
        logic [5:0] e0, e1;
        logic [1:0] es;
        model(e0, e1, es);
        chk({tag, ".inp0"}, 32'(inp0), 32'(e0));
        chk({tag, ".inp1"}, 32'(inp1), 32'(e1));
        chk({tag, ".inp2"}, 32'(inp2), 32'({1'b0, es}));
    endtask

    task automatic reset_dut();
        reset_n = 1'b0;
        joystk1 = '0;
        joystk2 = '0;
        vblank  = 1'b0;
        wait_clk(2);
        reset_n = 1'b1;
        foreach (kd[i]) kd[i] = 1'b0;
        wait_clk(2);
    endtask

    task automatic clr_cnt();
        hi = 0; rises = 0; hi0 = 0; rises0 = 0;
        prev = inp2[2]; prev0 = inp2_b[2];
    endtask

    // One video frame: vblank high for 2 clocks, low for 8; counts frames that begin with coin high.
    task automatic frame();
        if (inp2[2]) hi++;
        if (inp2_b[2]) hi0++;
        vblank = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_sys);
            if (i == 1) vblank = 1'b0;
            if (inp2[2] && !prev) rises++;
            if (inp2_b[2] && !prev0) rises0++;
            prev  = inp2[2];
            prev0 = inp2_b[2];
        end
    endtask

    initial begin
        logic [7:0] pool [14] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h16,
                                  8'h1E, 8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B};
        logic [7:0] code;
        wait_clk(2);
        chk("reset.inp0", 32'(inp0), 0);
        chk("reset.inp1", 32'(inp1), 0);
        chk("reset.inp2", 32'(inp2), 0);

        reset_n = 1'b1;
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h29};
        wait_clk(3);
        chk("prime_no_event", 32'(inp0[4]), 0);
        ps2_key = {1'b0, 1'b1, 1'b0, 8'h29};
        kd[8'h29] = 1'b1;
        wait_clk(1);
        chk("key_lat1", 32'(inp0[4]), 0);
        wait_clk(1);
        chk("key_lat2", 32'(inp0[4]), 1);

        send_key(1'b1, 8'h75, 1'b1);
        wait_clk(2);
        chk("ext_up_press", 32'(inp0[0]), 1);
        send_key(1'b0, 8'h75, 1'b0);
        wait_clk(2);
        chk("up_release", 32'(inp0[0]), 0);

        cabinet = 1'b0;
        joystk2 = 16'h0004;
        wait_clk(1);
        chk("fold.inp0", 32'(inp0[2]), 1);
        chk("fold.inp1", 32'(inp1[2]), 1);
        cabinet = 1'b1;
        wait_clk(1);
        chk("cocktail.inp0", 32'(inp0[2]), 0);
        chk("cocktail.inp1", 32'(inp1[2]), 1);
        joystk2 = '0;

        joystk1 = 16'h000C;
        wait_clk(1);
`ifdef DRUAGA_INPUT_SOCD_EN
        chk("socd.up", 32'(inp0[0]), 0);
        chk("socd.down", 32'(inp0[2]), 0);
`else
        chk("socd.up", 32'(inp0[0]), 1);
        chk("socd.down", 32'(inp0[2]), 1);
`endif
        joystk1 = '0;
        wait_clk(1);
        check_all("directed");

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                joystk1 = 16'($urandom) & 16'hFEFF;
                joystk2 = 16'($urandom) & 16'hFEFF;
                cabinet = 1'($urandom);
            end else begin
                code = pool[$urandom_range(0, 13)];
                if ($urandom_range(0, 5) == 0) code = 8'($urandom);
                if (code == 8'h2E || code == 8'h05 || code == 8'h06 || code == 8'h36) code = 8'h00;
                send_key(1'($urandom), code, 1'($urandom));
            end
            wait_clk(2);
            check_all("rand");
        end

        reset_dut();
        joystk1[8] = 1'b1;
        wait_clk(1);
        chk("coinA.start", 32'(inp2[2]), 1);
        chk("coinA.start_b", 32'(inp2_b[2]), 1);
        clr_cnt();
        repeat (20) frame();
        chk("coinA.frames", hi, 4);
        chk("coinA.retrig", rises, 0);
        chk("coinA.frames_b", hi0, 1);
        chk("coinA.retrig_b", rises0, 0);
        joystk1[8] = 1'b0;
        wait_clk(2);
        joystk1[8] = 1'b1;
        wait_clk(1);
        chk("coinA.second", 32'(inp2[2]), 1);
        clr_cnt();
        repeat (8) frame();
        chk("coinA.second_frames", hi, 4);
        joystk1[8] = 1'b0;
        wait_clk(2);

        send_key(1'b0, 8'h2E, 1'b1);
        wait_clk(2);
        chk("coinB.key", 32'(inp2[2]), 1);
        clr_cnt();
        frame();
        send_key(1'b0, 8'h2E, 1'b0);
        wait_clk(2);
        joystk2[8] = 1'b1;
        wait_clk(1);
        chk("coinB.mid", 32'(inp2[2]), 1);
        repeat (12) frame();
        chk("coinB.frames", hi, 4);
        chk("coinB.dropped", rises, 0);
        joystk2[8] = 1'b0;
        wait_clk(2);

        joystk1[8] = 1'b1;
        vblank = 1'b1;
        wait_clk(1);
        chk("coinC.coincident", 32'(inp2[2]), 1);
        wait_clk(1);
        vblank = 1'b0;
        wait_clk(2);
        clr_cnt();
        repeat (10) frame();
        chk("coinC.frames", hi, 4);
        joystk1[8] = 1'b0;
        wait_clk(2);

        joystk1[8] = 1'b1;
        wait_clk(1);
        frame();
        chk("coinD.pre", 32'(inp2[2]), 1);
        @(posedge clk_sys);
        #2 reset_n = 1'b0;
        joystk1[8] = 1'b0;
        #1 chk("coinD.async", 32'(inp2[2]), 0);
        wait_clk(2);
        reset_n = 1'b1;
        foreach (kd[i]) kd[i] = 1'b0;
        clr_cnt();
        repeat (3) frame();
        chk("coinD.idle", hi + rises, 0);
        joystk1[8] = 1'b1;
        wait_clk(1);
        chk("coinD.rearm", 32'(inp2[2]), 1);

        reset_dut();
        send_key(1'b0, 8'h05, 1'b1);
        wait_clk(2);
        chk("f1", 32'(inp2), 32'(3'b101));
        send_key(1'b0, 8'h06, 1'b1);
        wait_clk(2);
        chk("f2", 32'(inp2), 32'(3'b111));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
